// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - issue stage for the 8-bit ALU
// Registers one op toward the ALU, waits ALU_LAT cycles, captures F/flags for downstream.
module alu_issue_ctrl #(
    parameter int ALU_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [7:0]       IN_A,
    input  logic [7:0]       IN_B,
    input  logic [3:0]       IN_S,
    input  logic             IN_ACC,
    input  logic             CLEAR_ACC,
    output logic [7:0]       A,
    output logic [7:0]       B,
    output logic [3:0]       S,
    input  logic [7:0]       F,
    input  logic             EQUAL,
    input  logic             GT,
    input  logic             LT,
    input  logic             Zero,
    input  logic             CarryOut,
    input  logic             Overflow,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [7:0]       OUT_F,
    output logic [5:0]       OUT_FLAGS,
    output logic [7:0]       ACC,
    output logic [CNT_W-1:0] OP_CNT
);

    typedef enum logic [1:0] {IDLE, WAIT, RESULT} state_t;

    localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

    state_t           state_q;
    logic [3:0]       cnt_q;
    logic [7:0]       a_q, b_q, acc_q, out_f_q;
    logic [3:0]       s_q;
    logic [5:0]       out_flags_q;
    logic             out_valid_q;
    logic [CNT_W-1:0] op_cnt_q, op_cnt_d;
    logic [7:0]       a_d;
    logic             accept;

    assign IN_READY = !RST && (state_q == IDLE || (state_q == RESULT && OUT_READY));
    assign accept   = IN_VALID && IN_READY;
    // acc_q here is the pre-clear value, so a same-cycle CLEAR_ACC does not affect the accept
    assign a_d      = IN_ACC ? acc_q : IN_A;
    assign op_cnt_d = (&op_cnt_q) ? op_cnt_q : op_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            a_q         <= 8'd0;
            b_q         <= 8'd0;
            s_q         <= 4'd0;
            out_f_q     <= 8'd0;
            out_flags_q <= 6'd0;
            out_valid_q <= 1'b0;
            acc_q       <= 8'd0;
            op_cnt_q    <= '0;
        end else begin
            if (accept) begin
                a_q   <= a_d;
                b_q   <= IN_B;
                s_q   <= IN_S;
                cnt_q <= LAT_M1;
            end
            case (state_q)
                IDLE: if (accept) state_q <= WAIT;
                WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        out_f_q     <= F;
                        out_flags_q <= {Overflow, CarryOut, Zero, LT, GT, EQUAL};
                        acc_q       <= F;
                        op_cnt_q    <= op_cnt_d;
                        out_valid_q <= 1'b1;
                        state_q     <= RESULT;
                    end
                end
                RESULT: begin
                    if (OUT_READY) begin
                        out_valid_q <= 1'b0;
                        state_q     <= accept ? WAIT : IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
            // placed last so a clear wins over the WAIT capture into the accumulator
            if (CLEAR_ACC) acc_q <= 8'd0;
        end
    end

    assign A         = a_q;
    assign B         = b_q;
    assign S         = s_q;
    assign OUT_VALID = out_valid_q;
    assign OUT_F     = out_f_q;
    assign OUT_FLAGS = out_flags_q;
    assign ACC       = acc_q;
    assign OP_CNT    = op_cnt_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - self-checking bench for alu_issue_ctrl
module tb_alu_issue_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0, in_acc = 1'b0, clear_acc = 1'b0, out_ready = 1'b1;
    logic [7:0] in_a = 8'd0, in_b = 8'd0;
    logic [3:0] in_s = 4'd0;
    logic       sel = 1'b0;

    always #5 clk = ~clk;

    logic       in_valid0, in_valid1;
    assign in_valid0 = in_valid & ~sel;
    assign in_valid1 = in_valid & sel;

    logic        in_ready0, out_valid0, in_ready1, out_valid1;
    logic [7:0]  a0, b0, f0, out_f0, acc0, a1, b1, f1, out_f1, acc1;
    logic [3:0]  s0, s1;
    logic [5:0]  flags0, flags1;
    logic [15:0] op_cnt0;
    logic [1:0]  op_cnt1;

    // ALU stubs: F=A^B, EQUAL=(A==B), Zero=(F==0), remaining flags 0
    assign f0 = a0 ^ b0;
    assign f1 = a1 ^ b1;

    alu_issue_ctrl #(.ALU_LAT(1), .CNT_W(16)) dut (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid0), .IN_READY(in_ready0),
        .IN_A(in_a), .IN_B(in_b), .IN_S(in_s), .IN_ACC(in_acc), .CLEAR_ACC(clear_acc),
        .A(a0), .B(b0), .S(s0), .F(f0), .EQUAL(a0 == b0), .GT(1'b0), .LT(1'b0),
        .Zero(f0 == 8'd0), .CarryOut(1'b0), .Overflow(1'b0),
        .OUT_VALID(out_valid0), .OUT_READY(out_ready), .OUT_F(out_f0),
        .OUT_FLAGS(flags0), .ACC(acc0), .OP_CNT(op_cnt0)
    );

    alu_issue_ctrl #(.ALU_LAT(3), .CNT_W(2)) dut3 (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid1), .IN_READY(in_ready1),
        .IN_A(in_a), .IN_B(in_b), .IN_S(in_s), .IN_ACC(in_acc), .CLEAR_ACC(clear_acc),
        .A(a1), .B(b1), .S(s1), .F(f1), .EQUAL(a1 == b1), .GT(1'b0), .LT(1'b0),
        .Zero(f1 == 8'd0), .CarryOut(1'b0), .Overflow(1'b0),
        .OUT_VALID(out_valid1), .OUT_READY(out_ready), .OUT_F(out_f1),
        .OUT_FLAGS(flags1), .ACC(acc1), .OP_CNT(op_cnt1)
    );

    logic        in_ready_s, out_valid_s;
    logic [7:0]  a_s, out_f_s, acc_s;
    logic [3:0]  s_s;
    logic [5:0]  flags_s;
    logic [15:0] op_cnt_s;
    assign in_ready_s  = sel ? in_ready1  : in_ready0;
    assign out_valid_s = sel ? out_valid1 : out_valid0;
    assign a_s         = sel ? a1 : a0;
    assign s_s         = sel ? s1 : s0;
    assign out_f_s     = sel ? out_f1 : out_f0;
    assign flags_s     = sel ? flags1 : flags0;
    assign acc_s       = sel ? acc1 : acc0;
    assign op_cnt_s    = sel ? {14'd0, op_cnt1} : op_cnt0;

    typedef struct {
        logic [7:0] f;
        logic [5:0] fl;
    } res_t;
    res_t sb[$];

    typedef struct {
        logic [7:0] a, b;
        logic [3:0] s;
        logic       ua;
        logic [7:0] ea, ef;
        logic [5:0] fl;
    } vec_t;
    vec_t vecs[6];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic wait_result(input int lat, input logic clr, output int edges);
        edges = 1;
        while (!out_valid_s && edges < 40) begin
            if (clr && edges == lat) clear_acc = 1'b1;
            @(posedge clk); #1;
            clear_acc = 1'b0;
            edges++;
        end
        chk("latency", edges, lat + 1);
    endtask

    task automatic check_pop(input logic [7:0] eacc, input int ecnt);
        res_t r;
        chk("sb_nonempty", sb.size(), 1);
        if (sb.size() > 0) begin
            r = sb.pop_front();
            chk("OUT_F", out_f_s, r.f);
            chk("OUT_FLAGS", flags_s, r.fl);
        end
        chk("ACC", acc_s, eacc);
        chk("OP_CNT", op_cnt_s, ecnt);
    endtask

    task automatic issue(input logic [7:0] a, b, input logic [3:0] s, input logic ua,
                         input logic [7:0] ea, ef, input logic [5:0] fl,
                         input int lat, input int ecnt, input logic clr);
        int n;
        int edges;
        @(negedge clk);
        in_valid = 1'b1; in_a = a; in_b = b; in_s = s; in_acc = ua;
        n = 0;
        while (!in_ready_s && n < 20) begin @(negedge clk); n++; end
        chk("accept_wait", (n < 20), 1);
        sb.push_back('{f: ef, fl: fl});
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("A", a_s, ea);
        chk("S", s_s, s);
        wait_result(lat, clr, edges);
        check_pop(clr ? 8'd0 : ef, ecnt);
        if (out_ready) begin
            @(posedge clk); #1;
            chk("OUT_VALID_drop", out_valid_s, 0);
        end
    endtask

    initial begin
        int edges;
        vecs[0] = '{a: 8'h0F, b: 8'h05, s: 4'h0, ua: 1'b0, ea: 8'h0F, ef: 8'h0A, fl: 6'b000000};
        vecs[1] = '{a: 8'h3C, b: 8'h3C, s: 4'h1, ua: 1'b0, ea: 8'h3C, ef: 8'h00, fl: 6'b001001};
        vecs[2] = '{a: 8'h55, b: 8'hFF, s: 4'h2, ua: 1'b1, ea: 8'h00, ef: 8'hFF, fl: 6'b000000};
        vecs[3] = '{a: 8'h66, b: 8'h0F, s: 4'h3, ua: 1'b1, ea: 8'hFF, ef: 8'hF0, fl: 6'b000000};
        vecs[4] = '{a: 8'hAA, b: 8'h55, s: 4'hE, ua: 1'b0, ea: 8'hAA, ef: 8'hFF, fl: 6'b000000};
        vecs[5] = '{a: 8'h81, b: 8'h81, s: 4'h7, ua: 1'b0, ea: 8'h81, ef: 8'h00, fl: 6'b001001};

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_IN_READY", in_ready0, 0);
        chk("rst_OUT_VALID", out_valid0, 0);
        chk("rst_ACC", acc0, 0);
        chk("rst_OP_CNT", op_cnt0, 0);
        chk("rst_A", a0, 0);
        rst = 1'b0;
        #1 chk("post_rst_IN_READY", in_ready0, 1);

        for (int i = 0; i < 6; i++)
            issue(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].ua, vecs[i].ea, vecs[i].ef,
                  vecs[i].fl, 1, i + 1, 1'b0);

        // downstream stall with a pending op upstream
        out_ready = 1'b0;
        issue(8'h11, 8'h22, 4'h4, 1'b0, 8'h11, 8'h33, 6'b0, 1, 7, 1'b0);
        @(negedge clk);
        in_valid = 1'b1; in_a = 8'h44; in_b = 8'h04; in_s = 4'h5; in_acc = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_IN_READY", in_ready0, 0);
            chk("stall_OUT_F", out_f0, 8'h33);
            chk("stall_OUT_VALID", out_valid0, 1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1 chk("unstall_IN_READY", in_ready0, 1);
        sb.push_back('{f: 8'h40, fl: 6'b0});
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("b2b_A", a0, 8'h44);
        chk("b2b_OUT_VALID", out_valid0, 0);
        wait_result(1, 1'b0, edges);
        check_pop(8'h40, 8);
        @(posedge clk); #1;

        // clear on the capture cycle, then accumulate from the cleared value
        issue(8'h12, 8'h34, 4'h6, 1'b0, 8'h12, 8'h26, 6'b0, 1, 9, 1'b1);
        issue(8'h99, 8'h5A, 4'h6, 1'b1, 8'h00, 8'h5A, 6'b0, 1, 10, 1'b0);

        // reset while an op is in WAIT
        @(negedge clk);
        in_valid = 1'b1; in_a = 8'h77; in_b = 8'h01; in_acc = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("midrst_A", a0, 0);
        chk("midrst_OUT_F", out_f0, 0);
        chk("midrst_ACC", acc0, 0);
        chk("midrst_OP_CNT", op_cnt0, 0);
        chk("midrst_OUT_VALID", out_valid0, 0);
        chk("midrst_IN_READY", in_ready0, 0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("rel_IN_READY", in_ready0, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rel_no_OUT_VALID", out_valid0, 0);
        end
        chk("rel_OP_CNT", op_cnt0, 0);

        // ALU_LAT=3 instance, CNT_W=2 saturation
        sel = 1'b1;
        issue(8'h0F, 8'hF0, 4'h1, 1'b0, 8'h0F, 8'hFF, 6'b0, 3, 1, 1'b0);
        issue(8'h01, 8'h03, 4'h2, 1'b0, 8'h01, 8'h02, 6'b0, 3, 2, 1'b0);
        issue(8'h21, 8'h21, 4'h3, 1'b0, 8'h21, 8'h00, 6'b001001, 3, 3, 1'b0);
        issue(8'h80, 8'h01, 4'h4, 1'b0, 8'h80, 8'h81, 6'b0, 3, 3, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
